// File: rtl/delay_ctrl_pkg.sv
// Shared types and default parameters for the delay launch/capture path.
package delay_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    // Default configuration; TIMEOUT must stay below 2**CNT_W
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TIMEOUT     = 200;
    localparam int DEF_SETTLE_CYC  = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Latency count as reported at the default width
    typedef logic [DEF_CNT_W-1:0] count_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/delay_launch_ctrl.sv
// Launch/capture controller: drives one controlled edge into the delay chain,
// watches the synchronised return and reports loop latency in clock cycles.
module delay_launch_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             edge_sel,
    output logic             launch,
    input  logic             ret,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] count
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    logic             ret_sync;
    state_e           state_q,   state_d;
    logic             sel_q,     sel_d;
    logic             launch_q,  launch_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] settle_q,  settle_d;
    logic [SW-1:0]    stable_q,  stable_d;

    bit_sync #(.STAGES(SYNC_STAGES)) u_ret_sync (
        .clk (clk),
        .rst (rst),
        .d   (ret),
        .q   (ret_sync)
    );

    // Next-state and output decode; everything holds unless a state acts on it
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        launch_d  = launch_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        count_d   = count_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        stable_d  = stable_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d     = edge_sel;
                    count_d   = '0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    settle_d  = '0;
                    stable_d  = '0;
                    state_d   = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                // Hold the chain at its idle level until the return agrees
                launch_d = sel_q;
                if ((ret_sync == sel_q) && (stable_q == SW'(SETTLE_CYC - 1))) begin
                    // Launch edge (T0): measurement starts from zero
                    launch_d = ~sel_q;
                    cnt_d    = '0;
                    stable_d = '0;
                    state_d  = S_MEASURE;
                end else if (settle_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    count_d   = '0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                    if (ret_sync == sel_q) begin
                        stable_d = stable_q + SW'(1);
                    end else begin
                        stable_d = '0;
                    end
                end
            end
            S_MEASURE: begin
                // First sample at the launched level ends the measurement
                if (ret_sync == ~sel_q) begin
                    count_d = cnt_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d     = CNT_W'(TIMEOUT);
                    count_d   = CNT_W'(TIMEOUT);
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; rst returns all to idle with launch low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            launch_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            cnt_q     <= '0;
            settle_q  <= '0;
            stable_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            launch_q  <= launch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            stable_q  <= stable_d;
        end
    end

    assign launch  = launch_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign count   = count_q;

endmodule

// File: tb/tb_delay_launch_ctrl.sv
// Scoreboard bench for delay_launch_ctrl with a transport-delay loop model.
`timescale 1ns/1ps
module tb_delay_launch_ctrl;
    import delay_ctrl_pkg::*;

    localparam int CNT_W       = DEF_CNT_W;
    localparam int TIMEOUT     = DEF_TIMEOUT;
    localparam int SETTLE_CYC  = DEF_SETTLE_CYC;
    localparam int SYNC_STAGES = DEF_SYNC_STAGES;
    localparam int PERIOD_PS   = 10000;

    typedef struct {
        int count;
        int tmo;
        int launch_end;
        int latency;   // start-to-done cycles, -1 when not predicted
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       edge_sel = 1'b0;
    logic       ret;
    logic       launch, busy, done, timeout;
    count_t     count;

    logic       ret_loop = 1'b0;
    int         mode = 0;          // 0 loop, 1 ret tied 0, 2 ret tied 1
    real        loop_dly_ns = 0.68;
    int         model_launch = 0;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         busy_cyc = 0;
    bit         busy_prev = 1'b0;
    bit         done_prev = 1'b0;

    delay_launch_ctrl #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
        .SETTLE_CYC(SETTLE_CYC), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .edge_sel(edge_sel),
        .launch(launch), .ret(ret), .busy(busy), .done(done),
        .timeout(timeout), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural const_delay: transport delay of the launch signal
    always @(launch) ret_loop <= #(loop_dly_ns) launch;

    assign ret = (mode == 0) ? ret_loop : ((mode == 1) ? 1'b0 : 1'b1);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: latency from loop delay, or outcome of a constant return
    function automatic exp_t predict(input int m, input int sel, input int d_ps, input int prev_launch);
        exp_t e;
        if (m == 0) begin
            // return crosses after floor(d/T)+1 edges, then SYNC_STAGES-1 more to reach ret_sync
            e.count = d_ps / PERIOD_PS + SYNC_STAGES;
            e.tmo   = 0;
            if (e.count >= TIMEOUT) begin
                e.count = TIMEOUT;
                e.tmo   = 1;
            end
            e.launch_end = 1 - sel;
            e.latency    = (prev_launch == sel) ? SETTLE_CYC + e.count + 1 : -1;
        end else begin
            e.tmo = 1;
            if ((m == 2 ? 1 : 0) == sel) begin
                e.count      = TIMEOUT;
                e.launch_end = 1 - sel;
                e.latency    = SETTLE_CYC + TIMEOUT;
            end else begin
                e.count      = 0;
                e.launch_end = sel;
                e.latency    = TIMEOUT;
            end
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done_prev) begin
            chk("done_width", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end
        if (busy && !busy_prev) busy_cyc = cyc;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("count", int'(count), e.count);
                chk("timeout", int'(timeout), e.tmo);
                chk("launch_end", int'(launch), e.launch_end);
                chk("busy_in_done", int'(busy), 1);
                if (e.latency >= 0) chk("latency", cyc - busy_cyc, e.latency);
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    task automatic accept(input bit sel);
        start    = 1'b1;
        edge_sel = sel;
        @(posedge clk);
        #1;
        start    = 1'b0;
        edge_sel = 1'($urandom_range(0, 1));
        @(negedge clk);
        #1;
        chk("accept_busy", int'(busy), 1);
        chk("accept_timeout_clr", int'(timeout), 0);
        chk("accept_count_clr", int'(count), 0);
    endtask

    task automatic run(input int m, input bit sel, input int d_ps, input bit mid_pulse);
        exp_t e;
        int   n0;
        @(negedge clk);
        mode        = m;
        loop_dly_ns = d_ps / 1000.0;
        repeat (12) @(negedge clk);
        e = predict(m, int'(sel), d_ps, model_launch);
        sb_q.push_back(e);
        n0 = done_cnt;
        accept(sel);
        if (mid_pulse) begin
            repeat (5) @(negedge clk);
            start    = 1'b1;
            edge_sel = ~sel;
            @(negedge clk);
            start    = 1'b0;
        end
        for (int i = 0; i < 600 && done_cnt == n0; i++) @(posedge clk);
        if (done_cnt == n0) chk("done_wait_expired", 0, 1);
        repeat (4) @(posedge clk);
        chk("single_done", done_cnt - n0, 1);
        model_launch = e.launch_end;
    endtask

    task automatic back_to_back();
        exp_t e1, e2;
        int   n0;
        @(negedge clk);
        mode        = 0;
        loop_dly_ns = 0.68;
        repeat (12) @(negedge clk);
        e1 = predict(0, 0, 680, model_launch);
        e2 = predict(0, 0, 680, e1.launch_end);
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        n0 = done_cnt;
        start    = 1'b1;
        edge_sel = 1'b0;
        for (int i = 0; i < 1200 && done_cnt < n0 + 2; i++) begin
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        chk("held_start_dones", done_cnt - n0, 2);
        model_launch = e2.launch_end;
    endtask

    task automatic reset_mid_measure();
        @(negedge clk);
        mode        = 0;
        loop_dly_ns = 60.0;
        repeat (12) @(negedge clk);
        accept(1'b0);
        for (int i = 0; i < 100 && launch !== 1'b1; i++) @(posedge clk);
        chk("reached_measure", int'(launch), 1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_launch", int'(launch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_count", int'(count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_launch = 0;
    endtask

    // Stimulus: directed cases then randomized measurements
    initial begin
        int m, d;
        bit s;
        repeat (3) @(negedge clk);
        chk("reset_launch", int'(launch), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk("reset_count", int'(count), 0);
        rst = 1'b0;

        run(0, 1'b0, 680, 1'b0);     // rising edge, short loop
        run(0, 1'b1, 680, 1'b0);     // falling edge, short loop
        run(0, 1'b0, 25000, 1'b0);   // long loop
        run(1, 1'b0, 0, 1'b0);       // MEASURE timeout
        run(2, 1'b0, 0, 1'b0);       // SETTLE timeout
        run(0, 1'b0, 60000, 1'b1);   // start pulse while busy
        back_to_back();
        reset_mid_measure();
        run(0, 1'b0, 680, 1'b0);     // normal after reset

        for (int k = 0; k < 20; k++) begin
            m = $urandom_range(0, 8);
            m = (m < 7) ? 0 : m - 6;
            s = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 8) * PERIOD_PS + $urandom_range(400, 9600);
            run(m, s, d, 1'b0);
        end

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #900us;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
